// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register sitting directly in front of the ALU. Decodes the instruction in
//   the decode slot into ALU control and write-back/memory enables, latches operands and
//   immediate on the rising edge, and drives the ALU operand ports one cycle later. RAW hazards
//   are resolved by forwarding from EX/MEM and MEM/WB; load-use hazards raise stall and latch a
//   bubble so the ALU only ever sees valid instructions.
//
//   Build option: define FORWARDING_EN to include the EX/MEM and MEM/WB forwarding muxes.
//   Without it, operands come from the latched register-file data only, and stall also asserts
//   on any RAW dependency against the instruction in EX, EX/MEM or MEM/WB.
//
// Ports
//   clk, reset                   clock, asynchronous active-high reset
//   flush                        squash the instruction entering the stage
//   id_valid                     decode slot holds a real instruction
//   id_opcode, id_funct          instruction[31:26], instruction[5:0]
//   id_rs, id_rt, id_rd          source/destination register numbers
//   id_rs_data, id_rt_data       register-file read data
//   id_imm                       instruction[15:0]
//   exm_wr, exm_rd, exm_data     EX/MEM write-back candidate
//   mwb_wr, mwb_rd, mwb_data     MEM/WB write-back candidate
//   stall                        hold PC and IF/ID (combinational)
//   salida1, salida3             ALU operands A and B
//   control                      4-bit ALU control code
//   ex_valid, ex_reg_wr, ex_mem_rd, ex_mem_wr, ex_mem2reg   registered control
//   ex_dst                       destination register (rd for R-type, rt otherwise)
//   ex_store                     store data for sw (forwarded rt)
//   ex_illegal                   undecodable opcode/funct latched
// ---------------------------------------------------------------------------------------------
module id_ex_stage #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [5:0]            id_opcode,
    input  logic [5:0]            id_funct,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic [DATA_W-1:0]     id_rs_data,
    input  logic [DATA_W-1:0]     id_rt_data,
    input  logic [15:0]           id_imm,
    input  logic                  exm_wr,
    input  logic [REG_ADDR_W-1:0] exm_rd,
    input  logic [DATA_W-1:0]     exm_data,
    input  logic                  mwb_wr,
    input  logic [REG_ADDR_W-1:0] mwb_rd,
    input  logic [DATA_W-1:0]     mwb_data,
    output logic                  stall,
    output logic [DATA_W-1:0]     salida1,
    output logic [DATA_W-1:0]     salida3,
    output logic [3:0]            control,
    output logic                  ex_valid,
    output logic                  ex_reg_wr,
    output logic                  ex_mem_rd,
    output logic                  ex_mem_wr,
    output logic                  ex_mem2reg,
    output logic [REG_ADDR_W-1:0] ex_dst,
    output logic [DATA_W-1:0]     ex_store,
    output logic                  ex_illegal
);

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BGEZ  = 6'b000001;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type funct codes
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_NOR = 6'b100111;

    // ALU control codes
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_LUI  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_BNE  = 4'b1010;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_BGEZ = 4'b1111;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

    // Decode results for the instruction in the ID slot
    logic [3:0]            dec_control;
    logic                  dec_reg_wr;
    logic                  dec_mem_rd;
    logic                  dec_mem_wr;
    logic                  dec_mem2reg;
    logic                  dec_illegal;
    logic                  dec_use_imm;
    logic                  dec_zext;
    logic                  dec_rtype;
    logic [REG_ADDR_W-1:0] dec_dst;
    logic [DATA_W-1:0]     dec_imm;

    // Pipeline registers
    logic                  ex_valid_q;
    logic                  ex_reg_wr_q;
    logic                  ex_mem_rd_q;
    logic                  ex_mem_wr_q;
    logic                  ex_mem2reg_q;
    logic                  ex_illegal_q;
    logic                  ex_use_imm_q;
    logic [3:0]            control_q;
    logic [REG_ADDR_W-1:0] ex_dst_q;
    logic [REG_ADDR_W-1:0] ex_rs_q;
    logic [REG_ADDR_W-1:0] ex_rt_q;
    logic [DATA_W-1:0]     ex_rs_data_q;
    logic [DATA_W-1:0]     ex_rt_data_q;
    logic [DATA_W-1:0]     ex_imm_q;

    logic load_use;
    logic hazard;
    logic bubble;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;

    // -----------------------------------------------------------------------------------------
    // Decode
    // -----------------------------------------------------------------------------------------
    always_comb begin
        dec_control = ALU_ADD;
        dec_reg_wr  = 1'b0;
        dec_mem_rd  = 1'b0;
        dec_mem_wr  = 1'b0;
        dec_mem2reg = 1'b0;
        dec_illegal = 1'b0;
        dec_use_imm = 1'b0;
        dec_zext    = 1'b0;
        dec_rtype   = 1'b0;
        unique case (id_opcode)
            OP_RTYPE: begin
                dec_rtype  = 1'b1;
                dec_reg_wr = 1'b1;
                unique case (id_funct)
                    FN_ADD:  dec_control = ALU_ADD;
                    FN_SUB:  dec_control = ALU_SUB;
                    FN_AND:  dec_control = ALU_AND;
                    FN_OR:   dec_control = ALU_OR;
                    FN_SLT:  dec_control = ALU_SLT;
                    FN_NOR:  dec_control = ALU_NOR;
                    default: begin
                        dec_illegal = 1'b1;
                        dec_reg_wr  = 1'b0;
                    end
                endcase
            end
            OP_LW: begin
                dec_reg_wr  = 1'b1;
                dec_mem_rd  = 1'b1;
                dec_mem2reg = 1'b1;
                dec_use_imm = 1'b1;
            end
            OP_SW: begin
                dec_mem_wr  = 1'b1;
                dec_use_imm = 1'b1;
            end
            OP_ADDI: begin
                dec_reg_wr  = 1'b1;
                dec_use_imm = 1'b1;
            end
            OP_SLTI: begin
                dec_control = ALU_SLT;
                dec_reg_wr  = 1'b1;
                dec_use_imm = 1'b1;
            end
            OP_ANDI: begin
                dec_control = ALU_AND;
                dec_reg_wr  = 1'b1;
                dec_use_imm = 1'b1;
                dec_zext    = 1'b1;
            end
            OP_ORI: begin
                dec_control = ALU_OR;
                dec_reg_wr  = 1'b1;
                dec_use_imm = 1'b1;
                dec_zext    = 1'b1;
            end
            // The ALU does the 16-bit shift; we only hand it the zero-extended immediate.
            OP_LUI: begin
                dec_control = ALU_LUI;
                dec_reg_wr  = 1'b1;
                dec_use_imm = 1'b1;
                dec_zext    = 1'b1;
            end
            OP_BEQ:  dec_control = ALU_SUB;
            OP_BNE:  dec_control = ALU_BNE;
            OP_BGEZ: dec_control = ALU_BGEZ;
            default: dec_illegal = 1'b1;
        endcase
    end

    assign dec_dst = dec_rtype ? id_rd : id_rt;
    assign dec_imm = dec_zext ? {{(DATA_W-16){1'b0}}, id_imm}
                              : {{(DATA_W-16){id_imm[15]}}, id_imm};

    // -----------------------------------------------------------------------------------------
    // Hazard detection
    // -----------------------------------------------------------------------------------------
    assign load_use = ex_valid_q && ex_mem_rd_q && (ex_dst_q != REG_ZERO) &&
                      ((ex_dst_q == id_rs) || (ex_dst_q == id_rt)) && id_valid;

`ifdef FORWARDING_EN
    assign hazard = load_use;
`else
    // Without forwarding, any in-flight producer of a source register must drain first.
    function automatic logic raw_match(input logic [REG_ADDR_W-1:0] src);
        raw_match = (src != REG_ZERO) &&
                    ((ex_valid_q && ex_reg_wr_q && (ex_dst_q == src)) ||
                     (exm_wr && (exm_rd == src)) ||
                     (mwb_wr && (mwb_rd == src)));
    endfunction

    assign hazard = load_use || (id_valid && (raw_match(id_rs) || raw_match(id_rt)));
`endif

    // Reset clears EX state asynchronously; gating here also covers EX/MEM-driven stalls.
    assign stall  = hazard && !reset;
    assign bubble = !id_valid || flush || stall;

    // -----------------------------------------------------------------------------------------
    // ID/EX register
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid_q   <= 1'b0;
            ex_reg_wr_q  <= 1'b0;
            ex_mem_rd_q  <= 1'b0;
            ex_mem_wr_q  <= 1'b0;
            ex_mem2reg_q <= 1'b0;
            ex_illegal_q <= 1'b0;
            ex_use_imm_q <= 1'b0;
            control_q    <= ALU_ADD;
            ex_dst_q     <= '0;
            ex_rs_q      <= '0;
            ex_rt_q      <= '0;
            ex_rs_data_q <= '0;
            ex_rt_data_q <= '0;
            ex_imm_q     <= '0;
        end else begin
            ex_valid_q   <= !bubble;
            ex_reg_wr_q  <= !bubble && dec_reg_wr;
            ex_mem_rd_q  <= !bubble && dec_mem_rd;
            ex_mem_wr_q  <= !bubble && dec_mem_wr;
            ex_mem2reg_q <= !bubble && dec_mem2reg;
            ex_illegal_q <= !bubble && dec_illegal;
            control_q    <= bubble ? ALU_ADD : dec_control;
            // A squashed instruction leaves nothing behind, not even its operands.
            if (flush) begin
                ex_use_imm_q <= 1'b0;
                ex_dst_q     <= '0;
                ex_rs_q      <= '0;
                ex_rt_q      <= '0;
                ex_rs_data_q <= '0;
                ex_rt_data_q <= '0;
                ex_imm_q     <= '0;
            end else begin
                ex_use_imm_q <= dec_use_imm;
                ex_dst_q     <= dec_dst;
                ex_rs_q      <= id_rs;
                ex_rt_q      <= id_rt;
                ex_rs_data_q <= id_rs_data;
                ex_rt_data_q <= id_rt_data;
                ex_imm_q     <= dec_imm;
            end
        end
    end

    // -----------------------------------------------------------------------------------------
    // Operand selection
    // -----------------------------------------------------------------------------------------
`ifdef FORWARDING_EN
    // EX/MEM is younger than MEM/WB, so it wins when both target the same register.
    always_comb begin
        op_a = ex_rs_data_q;
        if (exm_wr && (exm_rd == ex_rs_q) && (ex_rs_q != REG_ZERO)) begin
            op_a = exm_data;
        end else if (mwb_wr && (mwb_rd == ex_rs_q) && (ex_rs_q != REG_ZERO)) begin
            op_a = mwb_data;
        end
    end

    always_comb begin
        op_b = ex_rt_data_q;
        if (exm_wr && (exm_rd == ex_rt_q) && (ex_rt_q != REG_ZERO)) begin
            op_b = exm_data;
        end else if (mwb_wr && (mwb_rd == ex_rt_q) && (ex_rt_q != REG_ZERO)) begin
            op_b = mwb_data;
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{exm_data, mwb_data, ex_rs_q, ex_rt_q};
    assign op_a = ex_rs_data_q;
    assign op_b = ex_rt_data_q;
`endif

    assign salida1    = op_a;
    assign salida3    = ex_use_imm_q ? ex_imm_q : op_b;
    assign ex_store   = op_b;
    assign control    = control_q;
    assign ex_valid   = ex_valid_q;
    assign ex_reg_wr  = ex_reg_wr_q;
    assign ex_mem_rd  = ex_mem_rd_q;
    assign ex_mem_wr  = ex_mem_wr_q;
    assign ex_mem2reg = ex_mem2reg_q;
    assign ex_dst     = ex_dst_q;
    assign ex_illegal = ex_illegal_q;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

    localparam logic [5:0] OP_R  = 6'b000000;
    localparam logic [5:0] OP_LW = 6'b100011;
    localparam logic [5:0] OP_SW = 6'b101011;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LUI  = 6'b001111;
    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        id_valid;
    logic [5:0]  id_opcode, id_funct;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_rs_data, id_rt_data;
    logic [15:0] id_imm;
    logic        exm_wr, mwb_wr;
    logic [4:0]  exm_rd, mwb_rd;
    logic [31:0] exm_data, mwb_data;
    logic        stall;
    logic [31:0] salida1, salida3, ex_store;
    logic [3:0]  control;
    logic        ex_valid, ex_reg_wr, ex_mem_rd, ex_mem_wr, ex_mem2reg, ex_illegal;
    logic [4:0]  ex_dst;

    int total = 0;
    int bad   = 0;

    // Expected EX-stage view of one latched instruction
    typedef struct {
        logic        valid;
        logic [3:0]  control;
        logic [31:0] s1;
        logic [31:0] s3;
        logic [4:0]  dst;
        logic        reg_wr;
        logic        mem_rd;
        logic        mem_wr;
        logic        illegal;
        logic [31:0] store;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(32), .REG_ADDR_W(5)) dut (
        .clk(clk), .reset(reset), .flush(flush), .id_valid(id_valid),
        .id_opcode(id_opcode), .id_funct(id_funct),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .exm_wr(exm_wr), .exm_rd(exm_rd), .exm_data(exm_data),
        .mwb_wr(mwb_wr), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
        .stall(stall), .salida1(salida1), .salida3(salida3), .control(control),
        .ex_valid(ex_valid), .ex_reg_wr(ex_reg_wr), .ex_mem_rd(ex_mem_rd),
        .ex_mem_wr(ex_mem_wr), .ex_mem2reg(ex_mem2reg), .ex_dst(ex_dst),
        .ex_store(ex_store), .ex_illegal(ex_illegal)
    );

    task automatic set_id(input logic v, input logic [5:0] op, input logic [5:0] fn,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [31:0] a, input logic [31:0] b, input logic [15:0] imm);
        id_valid = v; id_opcode = op; id_funct = fn;
        id_rs = rs; id_rt = rt; id_rd = rd;
        id_rs_data = a; id_rt_data = b; id_imm = imm;
    endtask

    task automatic clear_wb();
        exm_wr = 1'b0; exm_rd = '0; exm_data = '0;
        mwb_wr = 1'b0; mwb_rd = '0; mwb_data = '0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", ex_valid); end
        total++; if (control !== 4'b0010) begin bad++; $display("FAIL reset_control: got %b want 0010", control); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", stall); end
        reset = 1'b0;
    endtask

    task automatic test_add();
        exp_t e;
        clear_wb();
        set_id(1'b1, OP_R, F_ADD, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 16'h0);
        sb.push_back('{1'b1, 4'b0010, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 32'd7});
        @(negedge clk);
        e = sb.pop_front();
        total++; if (ex_valid !== e.valid) begin bad++; $display("FAIL add_valid: got %b want %b", ex_valid, e.valid); end
        total++; if (salida1 !== e.s1) begin bad++; $display("FAIL add_s1: got %h want %h", salida1, e.s1); end
        total++; if (salida3 !== e.s3) begin bad++; $display("FAIL add_s3: got %h want %h", salida3, e.s3); end
        total++; if (control !== e.control) begin bad++; $display("FAIL add_control: got %b want %b", control, e.control); end
        total++; if (ex_dst !== e.dst) begin bad++; $display("FAIL add_dst: got %0d want %0d", ex_dst, e.dst); end
        total++; if (ex_reg_wr !== e.reg_wr) begin bad++; $display("FAIL add_reg_wr: got %b want %b", ex_reg_wr, e.reg_wr); end
    endtask

    task automatic test_decode();
        // {opcode, funct, expected control}
        logic [15:0] tbl [15];
        exp_t e;
        tbl = '{{6'b000000, 6'b100010, 4'b0110}, {6'b000000, 6'b100100, 4'b0000},
                {6'b000000, 6'b100101, 4'b0001}, {6'b000000, 6'b101010, 4'b0111},
                {6'b000000, 6'b100111, 4'b1100}, {6'b100011, 6'b000000, 4'b0010},
                {6'b101011, 6'b000000, 4'b0010}, {6'b001000, 6'b000000, 4'b0010},
                {6'b000100, 6'b000000, 4'b0110}, {6'b000101, 6'b000000, 4'b1010},
                {6'b001111, 6'b000000, 4'b0101}, {6'b001100, 6'b000000, 4'b0000},
                {6'b001101, 6'b000000, 4'b0001}, {6'b001010, 6'b000000, 4'b0111},
                {6'b000001, 6'b000000, 4'b1111}};
        for (int i = 0; i < 15; i++) begin
            logic [15:0] row;
            row = tbl[i];
            // Register 0 everywhere keeps consecutive entries free of hazards.
            set_id(1'b1, row[15:10], row[9:4], 5'd0, 5'd0, 5'd0, 32'd1, 32'd2, 16'h0);
            sb.push_back('{1'b1, row[3:0], 32'd1, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd2});
            @(negedge clk);
            e = sb.pop_front();
            total++; if (control !== e.control) begin bad++; $display("FAIL decode_control[%0d]: got %b want %b", i, control, e.control); end
            total++; if (ex_illegal !== e.illegal) begin bad++; $display("FAIL decode_illegal[%0d]: got %b want %b", i, ex_illegal, e.illegal); end
        end
    endtask

    task automatic test_imm();
        exp_t e;
        set_id(1'b1, OP_ADDI, 6'd0, 5'd1, 5'd4, 5'd0, 32'd5, 32'd0, 16'hFFFF);
        sb.push_back('{1'b1, 4'b0010, 32'd5, 32'hFFFF_FFFF, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0});
        @(negedge clk);
        e = sb.pop_front();
        total++; if (salida3 !== e.s3) begin bad++; $display("FAIL addi_sext: got %h want %h", salida3, e.s3); end
        total++; if (ex_dst !== e.dst) begin bad++; $display("FAIL addi_dst: got %0d want %0d", ex_dst, e.dst); end
        set_id(1'b1, OP_ORI, 6'd0, 5'd1, 5'd5, 5'd0, 32'd5, 32'd0, 16'hFFFF);
        sb.push_back('{1'b1, 4'b0001, 32'd5, 32'h0000_FFFF, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0});
        @(negedge clk);
        e = sb.pop_front();
        total++; if (salida3 !== e.s3) begin bad++; $display("FAIL ori_zext: got %h want %h", salida3, e.s3); end
        set_id(1'b1, OP_LUI, 6'd0, 5'd0, 5'd6, 5'd0, 32'd0, 32'd0, 16'h8234);
        sb.push_back('{1'b1, 4'b0101, 32'd0, 32'h0000_8234, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0});
        @(negedge clk);
        e = sb.pop_front();
        total++; if (salida3 !== e.s3) begin bad++; $display("FAIL lui_zext: got %h want %h", salida3, e.s3); end
    endtask

    task automatic test_forward();
        exp_t e;
        exm_wr = 1'b1; exm_rd = 5'd1; exm_data = 32'd9;
        mwb_wr = 1'b1; mwb_rd = 5'd1; mwb_data = 32'd4;
        set_id(1'b1, OP_R, F_SUB, 5'd1, 5'd1, 5'd5, 32'd3, 32'd3, 16'h0);
        #1;
`ifdef FORWARDING_EN
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL fwd_nostall: got %b want 0", stall); end
        sb.push_back('{1'b1, 4'b0110, 32'd9, 32'd9, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 32'd9});
`else
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL raw_stall: got %b want 1", stall); end
        sb.push_back('{1'b0, 4'b0010, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0});
        @(negedge clk);
        e = sb.pop_front();
        total++; if (ex_valid !== e.valid) begin bad++; $display("FAIL raw_bubble: got %b want %b", ex_valid, e.valid); end
        clear_wb();
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL raw_release: got %b want 0", stall); end
        sb.push_back('{1'b1, 4'b0110, 32'd3, 32'd3, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 32'd3});
`endif
        @(negedge clk);
        e = sb.pop_front();
        total++; if (ex_valid !== e.valid) begin bad++; $display("FAIL fwd_valid: got %b want %b", ex_valid, e.valid); end
        total++; if (salida1 !== e.s1) begin bad++; $display("FAIL fwd_s1: got %h want %h", salida1, e.s1); end
        total++; if (salida3 !== e.s3) begin bad++; $display("FAIL fwd_s3: got %h want %h", salida3, e.s3); end
`ifdef FORWARDING_EN
        // MEM/WB alone feeds the operand when EX/MEM is idle.
        exm_wr = 1'b0;
        #1;
        total++; if (salida1 !== 32'd4) begin bad++; $display("FAIL fwd_mwb: got %h want 00000004", salida1); end
`endif
        // Register 0 sources are never forwarded.
        exm_wr = 1'b1; exm_rd = 5'd0; exm_data = 32'd9;
        mwb_wr = 1'b1; mwb_rd = 5'd0; mwb_data = 32'd4;
        set_id(1'b1, OP_R, F_SUB, 5'd0, 5'd0, 5'd5, 32'd8, 32'd8, 16'h0);
        sb.push_back('{1'b1, 4'b0110, 32'd8, 32'd8, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 32'd8});
        @(negedge clk);
        e = sb.pop_front();
        total++; if (salida1 !== e.s1) begin bad++; $display("FAIL r0_s1: got %h want %h", salida1, e.s1); end
        total++; if (salida3 !== e.s3) begin bad++; $display("FAIL r0_s3: got %h want %h", salida3, e.s3); end
        clear_wb();
    endtask

    task automatic test_load_use();
        exp_t e;
        set_id(1'b1, OP_LW, 6'd0, 5'd1, 5'd2, 5'd0, 32'd100, 32'd0, 16'h0004);
        sb.push_back('{1'b1, 4'b0010, 32'd100, 32'd4, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0});
        @(negedge clk);
        e = sb.pop_front();
        total++; if (ex_mem_rd !== e.mem_rd) begin bad++; $display("FAIL lw_mem_rd: got %b want %b", ex_mem_rd, e.mem_rd); end
        total++; if (salida3 !== e.s3) begin bad++; $display("FAIL lw_s3: got %h want %h", salida3, e.s3); end
        set_id(1'b1, OP_R, F_ADD, 5'd2, 5'd2, 5'd3, 32'd11, 32'd11, 16'h0);
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL lu_stall: got %b want 1", stall); end
        sb.push_back('{1'b0, 4'b0010, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0});
        @(negedge clk);
        e = sb.pop_front();
        total++; if (ex_valid !== e.valid) begin bad++; $display("FAIL lu_bubble_valid: got %b want %b", ex_valid, e.valid); end
        total++; if (ex_reg_wr !== e.reg_wr) begin bad++; $display("FAIL lu_bubble_reg_wr: got %b want %b", ex_reg_wr, e.reg_wr); end
        total++; if (ex_mem_rd !== e.mem_rd) begin bad++; $display("FAIL lu_bubble_mem_rd: got %b want %b", ex_mem_rd, e.mem_rd); end
        total++; if (control !== e.control) begin bad++; $display("FAIL lu_bubble_control: got %b want %b", control, e.control); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL lu_stall_drop: got %b want 0", stall); end
        sb.push_back('{1'b1, 4'b0010, 32'd11, 32'd11, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 32'd11});
        @(negedge clk);
        e = sb.pop_front();
        total++; if (ex_valid !== e.valid) begin bad++; $display("FAIL lu_issue_valid: got %b want %b", ex_valid, e.valid); end
        total++; if (ex_dst !== e.dst) begin bad++; $display("FAIL lu_issue_dst: got %0d want %0d", ex_dst, e.dst); end
        total++; if (salida1 !== e.s1) begin bad++; $display("FAIL lu_issue_s1: got %h want %h", salida1, e.s1); end
    endtask

    task automatic test_flush_illegal();
        exp_t e;
        flush = 1'b1;
        set_id(1'b1, OP_SW, 6'd0, 5'd1, 5'd6, 5'd0, 32'd20, 32'd30, 16'h0008);
        sb.push_back('{1'b0, 4'b0010, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0});
        @(negedge clk);
        e = sb.pop_front();
        total++; if (ex_valid !== e.valid) begin bad++; $display("FAIL flush_valid: got %b want %b", ex_valid, e.valid); end
        total++; if (ex_mem_wr !== e.mem_wr) begin bad++; $display("FAIL flush_mem_wr: got %b want %b", ex_mem_wr, e.mem_wr); end
        flush = 1'b0;
        sb.push_back('{1'b1, 4'b0010, 32'd20, 32'd8, 5'd6, 1'b0, 1'b0, 1'b1, 1'b0, 32'd30});
        @(negedge clk);
        e = sb.pop_front();
        total++; if (ex_mem_wr !== e.mem_wr) begin bad++; $display("FAIL sw_mem_wr: got %b want %b", ex_mem_wr, e.mem_wr); end
        total++; if (ex_reg_wr !== e.reg_wr) begin bad++; $display("FAIL sw_reg_wr: got %b want %b", ex_reg_wr, e.reg_wr); end
        total++; if (ex_store !== e.store) begin bad++; $display("FAIL sw_store: got %h want %h", ex_store, e.store); end
        total++; if (salida3 !== e.s3) begin bad++; $display("FAIL sw_s3: got %h want %h", salida3, e.s3); end
        set_id(1'b1, OP_R, 6'b111111, 5'd0, 5'd0, 5'd7, 32'd0, 32'd0, 16'h0);
        sb.push_back('{1'b1, 4'b0010, 32'd0, 32'd0, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0});
        @(negedge clk);
        e = sb.pop_front();
        total++; if (ex_illegal !== e.illegal) begin bad++; $display("FAIL badfunct_illegal: got %b want %b", ex_illegal, e.illegal); end
        total++; if (ex_reg_wr !== e.reg_wr) begin bad++; $display("FAIL badfunct_reg_wr: got %b want %b", ex_reg_wr, e.reg_wr); end
        total++; if (control !== e.control) begin bad++; $display("FAIL badfunct_control: got %b want %b", control, e.control); end
        set_id(1'b1, 6'b111111, 6'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 16'h0);
        sb.push_back('{1'b1, 4'b0010, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0});
        @(negedge clk);
        e = sb.pop_front();
        total++; if (ex_illegal !== e.illegal) begin bad++; $display("FAIL badop_illegal: got %b want %b", ex_illegal, e.illegal); end
        total++; if (ex_mem_wr !== e.mem_wr) begin bad++; $display("FAIL badop_mem_wr: got %b want %b", ex_mem_wr, e.mem_wr); end
    endtask

    task automatic test_reset_mid_stall();
        set_id(1'b1, OP_LW, 6'd0, 5'd1, 5'd2, 5'd0, 32'd0, 32'd0, 16'h0);
        @(negedge clk);
        set_id(1'b1, OP_R, F_ADD, 5'd2, 5'd2, 5'd3, 32'd0, 32'd0, 16'h0);
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL rst_pre_stall: got %b want 1", stall); end
        reset = 1'b1;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_stall: got %b want 0", stall); end
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", ex_valid); end
        total++; if (control !== 4'b0010) begin bad++; $display("FAIL rst_control: got %b want 0010", control); end
        @(negedge clk);
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL rst_hold_valid: got %b want 0", ex_valid); end
        reset = 1'b0;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_after_stall: got %b want 0", stall); end
        id_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        clear_wb();
        set_id(1'b0, 6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 16'h0);
        test_reset();
        test_add();
        test_decode();
        test_imm();
        test_forward();
        test_load_use();
        test_flush_illegal();
        test_reset_mid_stall();
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d entries want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
